// File: rtl/mining_bram_responder.sv
// Mining BRAM responder: 512-bit row store with 32-bit slice writes,
// registered whole-row reads, row-valid tracking and sticky range errors.
module mining_bram_responder #(
    parameter int DEPTH  = 64,
    parameter int ROW_W  = 512,
    parameter int WORD_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cs_n,
    input  logic              wr_n,
    input  logic              rd_n,
    input  logic [15:0]       addr,
    input  logic [8:0]        addr_width,
    input  logic [WORD_W-1:0] bram_data_in,
    output logic [ROW_W-1:0]  bram_data_out,
    output logic              rd_valid,
    output logic              err,
    output logic [15:0]       used_rows
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ROW_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0] row_valid;

    logic [AW-1:0]    idx;
    logic             in_range;
    logic             slice_ok;
    logic             wr_req;
    logic             rd_req;
    logic             wr_ok;
    logic             rd_bad;
    logic             wr_bad;
    logic [8:0]       lsb;
    logic [ROW_W-1:0] base_row;
    logic [ROW_W-1:0] word_mask;
    logic [ROW_W-1:0] word_bits;
    logic [ROW_W-1:0] merged_row;
    logic [ROW_W-1:0] rd_row;

    assign wr_req   = !cs_n && !wr_n;
    assign rd_req   = !cs_n && !rd_n;
    assign in_range = {1'b0, addr} < 17'(DEPTH);
    assign slice_ok = addr_width >= 9'(WORD_W - 1);
    assign idx      = addr[AW-1:0];

    // Writes are only committed out of reset so the array stays untouched.
    assign wr_ok  = reset && wr_req && in_range && slice_ok;
    assign wr_bad = wr_req && !(in_range && slice_ok);
    assign rd_bad = rd_req && !in_range;

    // Slice merge: an invalid row contributes zeros, the word lands at lsb.
    always_comb begin
        lsb        = addr_width - 9'(WORD_W - 1);
        base_row   = '0;
        if (in_range && row_valid[idx]) begin
            base_row = mem[idx];
        end
        word_mask  = {{(ROW_W-WORD_W){1'b0}}, {WORD_W{1'b1}}} << lsb;
        word_bits  = {{(ROW_W-WORD_W){1'b0}}, bram_data_in} << lsb;
        merged_row = (base_row & ~word_mask) | word_bits;
        rd_row     = wr_ok ? merged_row : base_row;
    end

    // Row storage has no reset; validity is tracked separately.
    always_ff @(posedge clock) begin
        if (wr_ok) begin
            mem[idx] <= merged_row;
        end
    end

    // Valid bits, occupancy count, sticky error and the read register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            row_valid     <= '0;
            used_rows     <= '0;
            err           <= 1'b0;
            rd_valid      <= 1'b0;
            bram_data_out <= '0;
        end else begin
            if (wr_ok) begin
                row_valid[idx] <= 1'b1;
                if (!row_valid[idx]) begin
                    used_rows <= used_rows + 16'd1;
                end
            end
            if (wr_bad || rd_bad) begin
                err <= 1'b1;
            end
            rd_valid <= rd_req;
            if (rd_req) begin
                bram_data_out <= rd_row;
            end
        end
    end

endmodule

// File: tb/tb_mining_bram_responder.sv
// Bench for mining_bram_responder: directed scenarios plus random traffic
// checked every cycle against a row-array model of the responder.
module tb_mining_bram_responder;

    localparam int DEPTH = 64;

    logic         clock;
    logic         reset;
    logic         cs_n;
    logic         wr_n;
    logic         rd_n;
    logic [15:0]  addr;
    logic [8:0]   addr_width;
    logic [31:0]  bram_data_in;
    logic [511:0] bram_data_out;
    logic         rd_valid;
    logic         err;
    logic [15:0]  used_rows;

    mining_bram_responder #(.DEPTH(DEPTH)) dut (
        .clock         (clock),
        .reset         (reset),
        .cs_n          (cs_n),
        .wr_n          (wr_n),
        .rd_n          (rd_n),
        .addr          (addr),
        .addr_width    (addr_width),
        .bram_data_in  (bram_data_in),
        .bram_data_out (bram_data_out),
        .rd_valid      (rd_valid),
        .err           (err),
        .used_rows     (used_rows)
    );

    logic [511:0] m_mem [DEPTH];
    bit           m_valid [DEPTH];
    int           m_used;
    bit           m_err;
    bit           m_rdv;
    logic [511:0] m_out;

    int n_checks = 0;
    int n_pass   = 0;

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string nm, input logic [511:0] act,
                       input logic [511:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 0;
        m_used = 0;
        m_err  = 0;
        m_rdv  = 0;
        m_out  = '0;
    endtask

    // Behavioural effect of one rising edge: write first, then read.
    task automatic model_step();
        bit           w;
        bit           r;
        bit           ok;
        int           a;
        logic [511:0] row;
        w  = !cs_n && !wr_n;
        r  = !cs_n && !rd_n;
        a  = int'(addr);
        ok = a < DEPTH;
        if (w) begin
            if (ok && addr_width >= 31) begin
                row = m_valid[a] ? m_mem[a] : '0;
                for (int i = 0; i < 32; i++)
                    row[int'(addr_width) - 31 + i] = bram_data_in[i];
                m_mem[a] = row;
                if (!m_valid[a]) m_used++;
                m_valid[a] = 1;
            end else begin
                m_err = 1;
            end
        end
        m_rdv = r;
        if (r) begin
            if (ok) begin
                m_out = m_valid[a] ? m_mem[a] : '0;
            end else begin
                m_out = '0;
                m_err = 1;
            end
        end
    endtask

    // Model advance and full output comparison on every cycle.
    always @(posedge clock) begin
        if (reset) model_step();
        #1;
        chk("bram_data_out", bram_data_out, m_out);
        chk("rd_valid", 512'(rd_valid), 512'(m_rdv));
        chk("err", 512'(err), 512'(m_err));
        chk("used_rows", 512'(used_rows), 512'(m_used));
    end

    task automatic idle();
        cs_n = 1;
        wr_n = 1;
        rd_n = 1;
    endtask

    task automatic op(input bit w, input bit r, input logic [15:0] a,
                      input logic [8:0] aw, input logic [31:0] d);
        cs_n         = 0;
        wr_n         = !w;
        rd_n         = !r;
        addr         = a;
        addr_width   = aw;
        bram_data_in = d;
        @(negedge clock);
        idle();
    endtask

    task automatic pulse_reset();
        reset = 0;
        model_reset();
        idle();
        @(negedge clock);
        reset = 1;
    endtask

    initial begin
        logic [511:0] exp;
        model_reset();
        reset        = 1;
        addr         = 0;
        addr_width   = 0;
        bram_data_in = 0;
        idle();
        #1 reset = 0;
        repeat (3) @(negedge clock);
        reset = 1;
        chk("reset_used", 512'(used_rows), 512'd0);
        chk("reset_err", 512'(err), 512'd0);

        op(0, 1, 0, 0, 0);
        chk("rd0_data", bram_data_out, 512'd0);
        chk("rd0_valid", 512'(rd_valid), 512'd1);

        op(1, 0, 3, 511, 32'hDEADBEEF);
        op(0, 1, 3, 0, 0);
        exp = {32'hDEADBEEF, 480'd0};
        chk("row3", bram_data_out, exp);
        chk("row3_used", 512'(used_rows), 512'd1);

        op(1, 0, 5, 63, 32'h7);
        op(0, 1, 5, 0, 0);
        op(1, 0, 5, 63, 32'h8);
        op(0, 1, 5, 0, 0);
        exp = {448'd0, 32'h8, 32'h0};
        chk("nonce_row", bram_data_out, exp);
        chk("nonce_used", 512'(used_rows), 512'd2);

        op(1, 1, 2, 31, 32'h12345678);
        chk("wr_through", bram_data_out, 512'h12345678);

        op(1, 0, 16'(DEPTH), 511, 32'hFFFFFFFF);
        chk("err_addr", 512'(err), 512'd1);
        op(1, 0, 0, 20, 32'hFFFFFFFF);
        op(0, 1, 0, 0, 0);
        chk("row0_untouched", bram_data_out, 512'd0);
        op(0, 1, 3, 0, 0);
        op(0, 1, 16'(DEPTH), 0, 0);
        chk("oob_rd_data", bram_data_out, 512'd0);
        chk("oob_rd_valid", 512'(rd_valid), 512'd1);
        chk("err_sticky", 512'(err), 512'd1);
        chk("oob_used", 512'(used_rows), 512'd3);

        for (int i = 0; i < 4; i++) op(1, 0, 16'(i), 95, 32'hA5A50000 + i);
        cs_n = 0;
        rd_n = 0;
        addr = 2;
        @(posedge clock);
        #2;
        reset = 0;
        model_reset();
        idle();
        #1;
        chk("async_data", bram_data_out, 512'd0);
        chk("async_valid", 512'(rd_valid), 512'd0);
        chk("async_used", 512'(used_rows), 512'd0);
        @(negedge clock);
        reset = 1;
        op(0, 1, 2, 0, 0);
        chk("post_rst_row2", bram_data_out, 512'd0);

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 299) == 0) begin
                pulse_reset();
            end else begin
                cs_n = ($urandom_range(0, 5) == 0);
                wr_n = $urandom_range(0, 1) == 1;
                rd_n = $urandom_range(0, 1) == 1;
                if ($urandom_range(0, 19) == 0)
                    addr = 16'(DEPTH + $urandom_range(0, 65535 - DEPTH));
                else
                    addr = 16'($urandom_range(0, 9));
                if ($urandom_range(0, 9) == 0)
                    addr_width = 9'($urandom_range(0, 30));
                else
                    addr_width = 9'($urandom_range(31, 511));
                bram_data_in = $urandom;
                @(negedge clock);
            end
        end
        idle();
        repeat (2) @(negedge clock);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
